// File: rtl/i2c_pkg.sv
// Shared definitions for the passive I2C receive path: FSM encoding,
// frame geometry and the byte bit-order helper.
package i2c_pkg;

  localparam int unsigned I2C_FRAME_BITS = 9;
  localparam int unsigned I2C_DATA_BITS  = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECV    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  // The shift register fills LSB-first while I2C sends MSB-first.
  function automatic logic [I2C_DATA_BITS-1:0] bit_rev(input logic [I2C_DATA_BITS-1:0] d);
    logic [I2C_DATA_BITS-1:0] r;
    for (int i = 0; i < I2C_DATA_BITS; i++) r[I2C_DATA_BITS-1-i] = d[i];
    return r;
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Per-line conditioning: reset-to-idle synchronizer, plus a stability
// filter when I2C_RX_FILTER_EN is defined.
module i2c_line_cond #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_cfg
    $error("i2c_line_cond: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], din};
  end

`ifdef I2C_RX_FILTER_EN
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] cnt;
  logic          filt;

  // Output follows only after FILTER_LEN consecutive disagreeing samples;
  // any return to the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= 1'b1;
    end else if (sync[SYNC_STAGES-1] == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      cnt  <= '0;
      filt <= sync[SYNC_STAGES-1];
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign dout = filt;
`else
  assign dout = sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/i2c_rx_framer.sv
// I2C bit-level receive framer: START/STOP detection, shift register
// control and byte framing. Optional line filter via I2C_RX_FILTER_EN.
module i2c_rx_framer
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scl_in,
  input  logic                      sda_in,
  input  logic [I2C_FRAME_BITS-1:0] sr_data,
  output logic                      shift_en,
  output logic                      shift_clr,
  output logic [I2C_DATA_BITS-1:0]  byte_data,
  output logic                      byte_ack,
  output logic                      byte_first,
  output logic                      byte_valid,
  output logic                      start_det,
  output logic                      stop_det,
  output logic                      busy
);

  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise;
  logic [1:0] state;
  logic [3:0] bit_cnt;
  logic       first_flg;
  logic [I2C_DATA_BITS-1:0] data_q;
  logic       ack_q, first_q;
  logic       cap;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .rst_n(rst_n), .din(scl_in), .dout(scl_s));
  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .rst_n(rst_n), .din(sda_in), .dout(sda_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign cap       = (state == ST_CAPTURE);

  assign shift_en  = (state == ST_RECV) & scl_rise & ~start_det & ~stop_det;
  assign shift_clr = cap | start_det | stop_det;

  // Frame outputs are live from sr_data during CAPTURE, then held.
  assign byte_valid = cap;
  assign byte_data  = cap ? bit_rev(sr_data[I2C_DATA_BITS-1:0]) : data_q;
  assign byte_ack   = cap ? ~sr_data[I2C_FRAME_BITS-1] : ack_q;
  assign byte_first = cap ? first_flg : first_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      first_flg <= 1'b0;
      busy      <= 1'b0;
      data_q    <= '0;
      ack_q     <= 1'b0;
      first_q   <= 1'b0;
    end else if (start_det) begin
      state     <= ST_RECV;
      bit_cnt   <= '0;
      first_flg <= 1'b1;
      busy      <= 1'b1;
    end else if (stop_det) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else if (cap) begin
      state     <= ST_RECV;
      bit_cnt   <= '0;
      first_flg <= 1'b0;
      data_q    <= byte_data;
      ack_q     <= byte_ack;
      first_q   <= byte_first;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 4'd1;
      if (bit_cnt == 4'(I2C_FRAME_BITS - 1)) state <= ST_CAPTURE;
    end
  end

endmodule

// File: tb/tb_i2c_rx_framer.sv
// Directed bench for i2c_rx_framer with a behavioural 9-bit shift register.
module tb_i2c_rx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_in = 1'b1, sda_in = 1'b1;
  logic [8:0] sr_data;
  logic       shift_en, shift_clr, byte_ack, byte_first, byte_valid;
  logic       start_det, stop_det, busy;
  logic [7:0] byte_data;

  int errs = 0, checks = 0;
  int en_cnt = 0, clr_cnt = 0, vld_cnt = 0, sta_cnt = 0, sto_cnt = 0;
  logic [7:0] cap_data;
  logic       cap_ack, cap_first;

  always #5 clk = ~clk;

  i2c_rx_framer dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in), .sr_data(sr_data),
    .shift_en(shift_en), .shift_clr(shift_clr), .byte_data(byte_data),
    .byte_ack(byte_ack), .byte_first(byte_first), .byte_valid(byte_valid),
    .start_det(start_det), .stop_det(stop_det), .busy(busy));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sr_data <= '0;
    else if (shift_clr) sr_data <= '0;
    else if (shift_en)  sr_data <= {sda_in, sr_data[8:1]};
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (shift_en)  en_cnt  <= en_cnt + 1;
      if (shift_clr) clr_cnt <= clr_cnt + 1;
      if (start_det) sta_cnt <= sta_cnt + 1;
      if (stop_det)  sto_cnt <= sto_cnt + 1;
      if (byte_valid) begin
        vld_cnt   <= vld_cnt + 1;
        cap_data  <= byte_data;
        cap_ack   <= byte_ack;
        cap_first <= byte_first;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    scl_in = 1'b0; sda_in = b; wclk(8);
    scl_in = 1'b1; wclk(8);
    scl_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic nine);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(nine);
    wclk(4);
  endtask

  task automatic do_start;
    sda_in = 1'b1; wclk(8);
    scl_in = 1'b1; wclk(8);
    sda_in = 1'b0; wclk(8);
    scl_in = 1'b0; wclk(4);
  endtask

  task automatic do_stop;
    scl_in = 1'b0; sda_in = 1'b0; wclk(8);
    scl_in = 1'b1; wclk(8);
    sda_in = 1'b1; wclk(8);
  endtask

  int e0, c0;

  initial begin
    wclk(5);
    @(negedge clk);
    chk("rst_shift_en", shift_en, 1'b0);
    chk("rst_shift_clr", shift_clr, 1'b0);
    chk("rst_valid", byte_valid, 1'b0);
    chk("rst_start", start_det, 1'b0);
    chk("rst_stop", stop_det, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_first", byte_first, 1'b0);
    chk("rst_ack", byte_ack, 1'b0);
    chk("rst_data", byte_data, 8'h00);
    rst_n = 1'b1;
    wclk(5);

    // First byte after START, ACK
    do_start;
    chk("start_cnt1", sta_cnt, 1);
    chk("busy_on", busy, 1'b1);
    e0 = en_cnt; c0 = clr_cnt;
    send_byte(8'hA5, 1'b0);
    chk("a5_shifts", en_cnt - e0, 9);
    chk("a5_vld", vld_cnt, 1);
    chk("a5_data", cap_data, 8'hA5);
    chk("a5_ack", cap_ack, 1'b1);
    chk("a5_first", cap_first, 1'b1);
    chk("a5_clr", clr_cnt - c0, 1);

    // Second byte, NACK
    e0 = en_cnt;
    send_byte(8'h3C, 1'b1);
    chk("3c_shifts", en_cnt - e0, 9);
    chk("3c_vld", vld_cnt, 2);
    chk("3c_data", cap_data, 8'h3C);
    chk("3c_ack", cap_ack, 1'b0);
    chk("3c_first", cap_first, 1'b0);
    wclk(3);
    chk("hold_data", byte_data, 8'h3C);
    chk("hold_valid", byte_valid, 1'b0);

    // STOP after 4 bits; the STOP's own SCL rise shifts a 5th bit
    e0 = en_cnt; c0 = clr_cnt;
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    do_stop;
    chk("stop_cnt", sto_cnt, 1);
    chk("stop_shifts", en_cnt - e0, 5);
    chk("stop_clr", clr_cnt - c0, 1);
    chk("stop_novld", vld_cnt, 2);
    chk("stop_busy", busy, 1'b0);

    // SCL pulses while idle must not shift
    e0 = en_cnt;
    scl_in = 1'b0; wclk(8); scl_in = 1'b1; wclk(8);
    chk("idle_noshift", en_cnt - e0, 0);

    // Repeated START after 6 bits, then FF with ACK
    do_start;
    e0 = en_cnt;
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    do_start;
    chk("rs_start_cnt", sta_cnt, 3);
    chk("rs_shifts", en_cnt - e0, 7);
    chk("rs_novld", vld_cnt, 2);
    send_byte(8'hFF, 1'b0);
    chk("ff_vld", vld_cnt, 3);
    chk("ff_data", cap_data, 8'hFF);
    chk("ff_first", cap_first, 1'b1);
    chk("ff_ack", cap_ack, 1'b1);

`ifdef I2C_RX_FILTER_EN
    // Short SCL low glitch while SCL high must not produce a shift
    e0 = en_cnt;
    scl_in = 1'b0; sda_in = 1'b1; wclk(8);
    scl_in = 1'b1; wclk(8);
    scl_in = 1'b0; wclk(2);
    scl_in = 1'b1; wclk(8);
    scl_in = 1'b0; wclk(4);
    chk("glitch_shifts", en_cnt - e0, 1);
`endif

    // Async reset mid-byte
    do_start;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_data", byte_data, 8'h00);
    chk("arst_valid", byte_valid, 1'b0);
    scl_in = 1'b1; sda_in = 1'b1;
    wclk(4);
    rst_n = 1'b1;
    wclk(4);
    e0 = en_cnt; c0 = vld_cnt;
    send_byte(8'h55, 1'b0);
    chk("arst_noshift", en_cnt - e0, 0);
    chk("arst_novld", vld_cnt - c0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/i2c_rx_framer.md
# i2c_rx_framer

Bit-level front end for the passive I2C listener. Synchronizes raw SCL/SDA, detects START/STOP, and drives `shift_en`/`shift_clr` on the 9-bit right shift register that samples SDA. After the 9th bit it reads the register back and emits one frame: data byte, ACK flag and first-byte-after-START flag. Sits between the bus pins and the byte-level decoder.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per line (≥2).
- `FILTER_LEN`, 3: glitch-filter length in `clk` cycles; used only with `I2C_RX_FILTER_EN`.
- `clk` in 1: system clock; must run ≥8× SCL frequency.
- `rst_n` in 1: reset, asynchronous, active-low.
- `scl_in` in 1: raw SCL pin.
- `sda_in` in 1: raw SDA pin; also wired directly to the shift register data input.
- `sr_data` in 9: shift register parallel output.
- `shift_en` out 1: shift strobe to the shift register.
- `shift_clr` out 1: synchronous clear to the shift register.
- `byte_data` out 8: received byte, MSB-first order restored.
- `byte_ack` out 1: 1 when the 9th bit was low (ACK).
- `byte_first` out 1: frame is the first byte after START or repeated START.
- `byte_valid` out 1: one-cycle pulse qualifying `byte_data`, `byte_ack` and `byte_first`.
- `start_det`, `stop_det` out 1: one-cycle condition pulses.
- `busy` out 1: bus owned (START seen, STOP not yet seen).

## Operation
- Synchronizer flops reset to 1 (idle bus). Edges are taken from the last stage against a registered copy.
- `scl_rise`: SCL goes 0→1.
- START: SDA falls while SCL=1 (both samples). STOP: SDA rises while SCL=1.
- FSM states:
  - IDLE → RECV on START.
  - RECV → CAPTURE when the 9th `scl_rise` is counted.
  - CAPTURE → RECV, unconditionally after one cycle.
  - RECV or CAPTURE → IDLE on STOP.
  - START in any state → RECV.
- `shift_en`: one-cycle pulse on each `scl_rise` in RECV. It coincides with the `bit_cnt` increment. `bit_cnt` counts 0..9 (4 bits) and is cleared on START, STOP and CAPTURE.
- CAPTURE (the cycle after the 9th `shift_en`, when `sr_data` holds all 9 bits):
  - `byte_data[7-i] = sr_data[i]` for i=0..7. The first bit received is at `sr_data[0]`.
  - `byte_ack = ~sr_data[8]`.
  - `byte_first` = first-byte flag, which is then cleared. The flag is set on START.
  - `byte_valid` = 1.
  - `shift_clr` = 1.
- `shift_clr` also pulses for one cycle on every START and STOP.
- STOP or START mid-byte (`bit_cnt` 1..8): the partial byte is discarded, no `byte_valid`.
- `busy`: set on START, cleared on STOP.
- `scl_rise` in IDLE: ignored, no `shift_en`.

## Timing
- Reset values: `shift_en`, `shift_clr`, `byte_valid`, `start_det`, `stop_det`, `busy`, `byte_first`, `byte_ack` = 0; `byte_data` = 8'h00; FSM = IDLE; `bit_cnt` = 0.
- Pin-to-detection latency: SYNC_STAGES+1 cycles (plus FILTER_LEN when filtered).
- `byte_valid` asserts exactly 1 cycle after the 9th `shift_en`. Frame outputs hold their values until the next CAPTURE.
- START and STOP detected in the same cycle cannot occur (single SDA edge). START takes priority over `scl_rise` in the same cycle.
- Async reset mid-byte: all state returns to reset values immediately. Reception resumes only after a fresh START.

## Configuration
- `I2C_RX_FILTER_EN` defined: each synchronized line passes through a majority-free stability filter. The output changes only after the input has been stable for FILTER_LEN consecutive cycles. Filter outputs reset to 1.
- Not defined: the synchronizer output feeds edge detection directly, and FILTER_LEN is unused.

## Structure
- Shared package `i2c_pkg`:
  - FSM state encoding (IDLE, RECV, CAPTURE).
  - `I2C_FRAME_BITS` = 9.
  - `I2C_DATA_BITS` = 8.
- Sub-module `i2c_line_cond`: per-line synchronizer plus optional filter, instantiated twice (SCL, SDA).

## Test plan
- Reset: `rst_n` low with `scl_in`=`sda_in`=1 → every output at its reset value, `busy`=0.
- START, bits 1,0,1,0,0,1,0,1 then ACK (SDA=0) → 9 `shift_en` pulses, `byte_valid` with `byte_data`=8'hA5, `byte_ack`=1, `byte_first`=1, then `shift_clr`.
- Second byte 8'h3C with NACK → `byte_data`=8'h3C, `byte_ack`=0, `byte_first`=0.
- STOP after 4 bits → `stop_det`, `shift_clr`, no `byte_valid`, `busy`=0, FSM IDLE.
- Repeated START after 6 bits, then 8'hFF + ACK → partial byte discarded, `start_det`, `byte_data`=8'hFF, `byte_first`=1.
- With `I2C_RX_FILTER_EN`, FILTER_LEN=3: 2-cycle SCL glitch low during RECV → no extra `shift_en`, `bit_cnt` unchanged.
